// File: rtl/mont_pkg.sv
// rtl/mont_pkg.sv - shared command codes, FSM state encoding and LED indices for mont_cmd_ctrl
package mont_pkg;

    localparam int WORD_LEN = 512;

    localparam logic [31:0] CMD_READ    = 32'd0;
    localparam logic [31:0] CMD_COMPUTE = 32'd1;
    localparam logic [31:0] CMD_WRITE   = 32'd2;

    // Encoding is visible on leds[2:0], so the values are part of the host-facing contract
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RD_WAIT   = 3'd1,
        ST_CMP_START = 3'd2,
        ST_CMP_WAIT  = 3'd3,
        ST_WR_WAIT   = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    localparam int LED_STATE_LSB = 0;
    localparam int LED_STATE_MSB = 2;
    localparam int LED_ERR       = 3;

endpackage

// File: rtl/mont_cmd_ctrl_if.sv
// rtl/mont_cmd_ctrl_if.sv - host command, BRAM and core-side signal bundle for mont_cmd_ctrl
interface mont_cmd_ctrl_if;
    import mont_pkg::*;

    logic [31:0]         port1_din;
    logic                port1_valid;
    logic                port1_read;
    logic                port2_valid;
    logic                port2_read;
    logic [WORD_LEN-1:0] bram_din1;
    logic [WORD_LEN-1:0] bram_din2;
    logic                bram_din_valid;
    logic [WORD_LEN-1:0] bram_dout1;
    logic [WORD_LEN-1:0] bram_dout2;
    logic                bram_dout1_valid;
    logic                bram_dout2_valid;
    logic                bram_dout_read;
    logic                core_start;
    logic [WORD_LEN-1:0] core_a1;
    logic [WORD_LEN-1:0] core_a2;
    logic                core_done1;
    logic                core_done2;
    logic [WORD_LEN-1:0] core_res1;
    logic [WORD_LEN-1:0] core_res2;
    logic [3:0]          leds;

    modport master (
        output port1_din, port1_valid, port2_read,
        output bram_din1, bram_din2, bram_din_valid, bram_dout_read,
        output core_done1, core_done2, core_res1, core_res2,
        input  port1_read, port2_valid,
        input  bram_dout1, bram_dout2, bram_dout1_valid, bram_dout2_valid,
        input  core_start, core_a1, core_a2, leds
    );

    modport slave (
        input  port1_din, port1_valid, port2_read,
        input  bram_din1, bram_din2, bram_din_valid, bram_dout_read,
        input  core_done1, core_done2, core_res1, core_res2,
        output port1_read, port2_valid,
        output bram_dout1, bram_dout2, bram_dout1_valid, bram_dout2_valid,
        output core_start, core_a1, core_a2, leds
    );

endinterface

// File: rtl/mont_cmd_handshake.sv
// rtl/mont_cmd_handshake.sv - port1 four-phase handshake: armed flag, port1_read and accept pulse
module mont_cmd_handshake
    import mont_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic port1_valid,
    input  logic ready,
    output logic port1_read,
    output logic accept
);

    logic armed;

    // A valid that stays high after acceptance must not start a second command
    assign accept = port1_valid && armed && ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            armed      <= 1'b1;
            port1_read <= 1'b0;
        end else begin
            port1_read <= accept || (port1_read && port1_valid);
            if (accept) begin
                armed <= 1'b0;
            end else if (!port1_valid) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mont_cmd_ctrl.sv
// rtl/mont_cmd_ctrl.sv - Montgomery command controller top; lane 2 present only with MONT_DUAL_CORE_EN
module mont_cmd_ctrl
    import mont_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    mont_cmd_ctrl_if.slave bus
);

    state_t              state;
    state_t              state_next;
    logic                err;
    logic                err_next;
    logic                accept;
    logic [WORD_LEN-1:0] a1;
    logic [WORD_LEN-1:0] res1;
    logic                done1;
    logic                lane1_hit;
    logic                lane2_hit;

    mont_cmd_handshake u_handshake (
        .clk         (clk),
        .resetn      (resetn),
        .port1_valid (bus.port1_valid),
        .ready       (state == ST_IDLE),
        .port1_read  (bus.port1_read),
        .accept      (accept)
    );

    // A done arriving on the same edge as the completing one counts immediately
    assign lane1_hit = done1 || bus.core_done1;

    always_comb begin
        state_next = state;
        err_next   = err;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (bus.port1_din)
                        CMD_READ:    state_next = ST_RD_WAIT;
                        CMD_COMPUTE: state_next = ST_CMP_START;
                        CMD_WRITE:   state_next = ST_WR_WAIT;
                        default: begin
                            state_next = ST_DONE;
                            err_next   = 1'b1;
                        end
                    endcase
                end
            end
            ST_RD_WAIT:   if (bus.bram_din_valid) state_next = ST_DONE;
            ST_CMP_START: state_next = ST_CMP_WAIT;
            ST_CMP_WAIT:  if (lane1_hit && lane2_hit) state_next = ST_DONE;
            ST_WR_WAIT:   if (bus.bram_dout_read) state_next = ST_DONE;
            ST_DONE:      if (bus.port2_read) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    assign bus.core_a1 = a1;

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state                <= ST_IDLE;
            err                  <= 1'b0;
            a1                   <= '0;
            res1                 <= '0;
            done1                <= 1'b0;
            bus.port2_valid      <= 1'b0;
            bus.core_start       <= 1'b0;
            bus.bram_dout1       <= '0;
            bus.bram_dout1_valid <= 1'b0;
            bus.leds             <= 4'h0;
        end else begin
            state <= state_next;
            err   <= err_next;
            if (state == ST_RD_WAIT && bus.bram_din_valid) begin
                a1 <= bus.bram_din1;
            end
            if (state == ST_CMP_START) begin
                done1 <= 1'b0;
            end else if (state == ST_CMP_WAIT && bus.core_done1) begin
                done1 <= 1'b1;
                res1  <= bus.core_res1;
            end
            bus.port2_valid      <= (state_next == ST_DONE);
            bus.core_start       <= (state_next == ST_CMP_START);
            bus.bram_dout1_valid <= (state_next == ST_WR_WAIT);
            bus.bram_dout1       <= (state_next == ST_WR_WAIT) ? res1 : '0;
            bus.leds             <= {err_next, state_next};
        end
    end

`ifdef MONT_DUAL_CORE_EN
    logic [WORD_LEN-1:0] a2;
    logic [WORD_LEN-1:0] res2;
    logic                done2;

    assign lane2_hit   = done2 || bus.core_done2;
    assign bus.core_a2 = a2;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a2                   <= '0;
            res2                 <= '0;
            done2                <= 1'b0;
            bus.bram_dout2       <= '0;
            bus.bram_dout2_valid <= 1'b0;
        end else begin
            if (state == ST_RD_WAIT && bus.bram_din_valid) begin
                a2 <= bus.bram_din2;
            end
            if (state == ST_CMP_START) begin
                done2 <= 1'b0;
            end else if (state == ST_CMP_WAIT && bus.core_done2) begin
                done2 <= 1'b1;
                res2  <= bus.core_res2;
            end
            bus.bram_dout2_valid <= (state_next == ST_WR_WAIT);
            bus.bram_dout2       <= (state_next == ST_WR_WAIT) ? res2 : '0;
        end
    end
`else
    logic unused_lane2;

    assign unused_lane2         = ^{bus.bram_din2, bus.core_done2, bus.core_res2};
    assign lane2_hit            = 1'b1;
    assign bus.core_a2          = '0;
    assign bus.bram_dout2       = '0;
    assign bus.bram_dout2_valid = 1'b0;
`endif

endmodule

// File: doc/mont_cmd_ctrl.md
# mont_cmd_ctrl

Responder-side command controller for the Montgomery RSA accelerator. It accepts 32-bit commands from the host on port1 and moves 512-bit operands in from the BRAM port. It starts the Montgomery core(s), returns results over the BRAM output port, and signals completion on port2. It sits between the ARM-facing handshake ports and the core instances inside the accelerator top level.

## Interface
- WORD_LEN, 512, operand/result width per lane
- clk  in  1  system clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- port1_din  in  32  command word
- port1_valid  in  1  command present (host holds until port1_read seen)
- port1_read  out  1  command acknowledged
- port2_valid  out  1  command complete
- port2_read  in  1  host acknowledges completion
- bram_din1, bram_din2  in  WORD_LEN  operand lane 1/2
- bram_din_valid  in  1  operand strobe
- bram_dout1, bram_dout2  out  WORD_LEN  result lane 1/2
- bram_dout1_valid, bram_dout2_valid  out  1  result present
- bram_dout_read  in  1  host has taken results
- core_start  out  1  one-cycle start pulse to cores
- core_a1, core_a2  out  WORD_LEN  latched operands to cores
- core_done1, core_done2  in  1  core completion pulses
- core_res1, core_res2  in  WORD_LEN  core results, valid with done
- leds  out  4  status

## Operation
- Commands: CMD_READ=0, CMD_COMPUTE=1, CMD_WRITE=2; any other value is illegal.
- States: IDLE, RD_WAIT, CMP_START, CMP_WAIT, WR_WAIT, DONE.
- Transitions:
  - IDLE + port1_valid + armed: latch command, decode. 0→RD_WAIT, 1→CMP_START, 2→WR_WAIT, illegal→DONE with err set.
  - RD_WAIT: waits for bram_din_valid, latches din1/din2 into a1/a2, →DONE.
  - CMP_START: drives core_start=1 for exactly one cycle, clears done flags, →CMP_WAIT.
  - CMP_WAIT: latches core_resN into resN on core_doneN; sticky flags. Both flags set →DONE.
  - WR_WAIT: dout valids high, dout = res1/res2. On bram_dout_read, valids drop, →DONE.
  - DONE: port2_valid=1 until port2_read sampled high, then →IDLE.
- Port1 four-phase handshake:
  - port1_read rises the cycle after acceptance and stays high while port1_valid=1.
  - It clears the cycle after port1_valid is sampled low.
  - armed=0 from acceptance until port1_valid is sampled low. A valid held high never re-triggers.
- port1_valid while not IDLE: not accepted, port1_read stays 0.
- bram_din_valid outside RD_WAIT, core_doneN outside CMP_WAIT, and bram_dout_read outside WR_WAIT are ignored.
- leds[2:0] = state encoding. leds[3] = sticky illegal-command flag, cleared only by reset.

## Timing
- All outputs are registered. Reset values: every output 0; a1, a2, res1, res2 cleared; state IDLE; armed=1.
- Reset mid-operation: immediate return to IDLE. Any in-flight core_done is discarded.
- Accept at edge N: port1_read=1 and new state from N+1.
- CMD_READ: strobe sampled at edge M → port2_valid=1 from M+1.
- CMD_COMPUTE: core_start high during cycle N+1 only. Both dones sampled (same or different edges), last at edge K → port2_valid from K+1.
- CMD_WRITE: dout valids from N+1. bram_dout_read sampled at edge M → valids 0 and port2_valid 1 from M+1.
- DONE: port2_read sampled at edge P → port2_valid 0 and IDLE from P+1. The next command is accepted no earlier than P+1.

## Configuration
- MONT_DUAL_CORE_EN defined: both lanes active as above.
- MONT_DUAL_CORE_EN undefined:
  - lane 2 is removed; bram_dout2, bram_dout2_valid, and core_a2 are tied 0;
  - bram_din2, core_done2, and core_res2 are ignored;
  - CMP_WAIT exits on core_done1 alone.

## Structure
- mont_pkg holds: command codes; the state enum (3-bit encoding, IDLE=0 … DONE=5); LED bit indices.
- Sub-module mont_cmd_handshake holds the port1 four-phase logic: armed flag, port1_read register, one-cycle accept pulse to the FSM.
- Operand/result registers and the FSM stay in mont_cmd_ctrl.

## Test plan
- Reset: assert resetn=0 mid-RD_WAIT → all outputs 0, leds=4'h0. A following CMD_READ is accepted normally.
- CMD_READ: port1_din=0, then bram_din1=512'hb90a…903a, bram_din2=512'he74c…62c3f3 → core_a1/core_a2 hold those values; port2_valid one cycle after the strobe; cleared after port2_read.
- CMD_COMPUTE: port1_din=1, core_done1 at +5 cycles with res1=512'h1, core_done2 at +9 with res2=512'h2 → single core_start pulse; port2_valid one cycle after the +9 edge.
- CMD_WRITE: port1_din=2 → dout1=512'h1 and dout2=512'h2 with both valids high until bram_dout_read, then port2_valid.
- Illegal/held command: port1_din=32'h7 → port2_valid without any core or BRAM activity; leds[3]=1. Holding port1_valid across DONE→IDLE produces no second acceptance.
- Single-lane build (no MONT_DUAL_CORE_EN): CMD_COMPUTE completes on core_done1 alone; bram_dout2_valid stays 0 throughout CMD_WRITE.
